// File: rtl/dbg_target_port_if.sv
// Command/handshake bundle between the UART debug controller (master) and
// dbg_target_port (slave): command strobes in, busy/read-back/status out.
interface dbg_target_port_if;
  logic        valid;
  logic        pause;
  logic        resume;
  logic        reset;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_rd;
  logic        reg_wr;
  logic [1:0]  mem_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] rdata;
  logic        halted;
  logic        access_err;

  modport master (
    output valid, pause, resume, reset, mem_rd, mem_wr, reg_rd, reg_wr,
           mem_size, addr, wdata,
    input  busy, rdata, halted, access_err
  );

  modport slave (
    input  valid, pause, resume, reset, mem_rd, mem_wr, reg_rd, reg_wr,
           mem_size, addr, wdata,
    output busy, rdata, halted, access_err
  );
endinterface

// File: rtl/dbg_target_port.sv
// MCU-side responder for debugger command strobes: halts/resets the core and runs
// data-memory and register-file accesses. Optional access timeout: DBG_MEM_TIMEOUT_EN.
module dbg_target_port #(
  parameter int PAUSE_DRAIN = 2,
  parameter int RST_CYCLES  = 4
`ifdef DBG_MEM_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  dbg_target_port_if.slave  dbg,
  output logic              cpu_halt,
  output logic              cpu_rst,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [1:0]        dmem_size,
  output logic [31:0]       dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              rf_en,
  output logic              rf_we,
  output logic [4:0]        rf_addr,
  output logic [31:0]       rf_wdata,
  input  logic [31:0]       rf_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAIN  = 3'd1;
  localparam logic [2:0] RST    = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] REG_RD = 3'd4;
  localparam logic [2:0] REG_WR = 3'd5;

  localparam int CNT_MAX = (PAUSE_DRAIN > RST_CYCLES) ? PAUSE_DRAIN : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             halted_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             is_access;

  assign is_access      = dbg.mem_wr | dbg.mem_rd | dbg.reg_wr | dbg.reg_rd;
  assign dbg.busy       = dbg.valid | (state != IDLE);
  assign dbg.rdata      = rdata_q;
  assign dbg.halted     = halted_q;
  assign dbg.access_err = err_q;

  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return {24'b0, d[7:0]};
      2'd1:    return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

`ifdef DBG_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Counts cycles the request has been outstanding; restarts with each new command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (dbg.valid && (state == IDLE))
      tmo_cnt <= '0;
    else if (state == MEM)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
`endif

  // Command decode happens only in IDLE; strobe priority is the if/else order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      halted_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cpu_halt   <= 1'b0;
      cpu_rst    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_size  <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rf_en      <= 1'b0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg.valid) begin
            if (dbg.reset) begin
              cpu_rst  <= 1'b1;
              cpu_halt <= 1'b0;
              halted_q <= 1'b0;
              cnt      <= CNT_W'(RST_CYCLES - 1);
              state    <= RST;
            end else if (dbg.pause) begin
              if (!halted_q) begin
                cpu_halt <= 1'b1;
                cnt      <= CNT_W'(PAUSE_DRAIN - 1);
                state    <= DRAIN;
              end
            end else if (dbg.resume) begin
              cpu_halt <= 1'b0;
              halted_q <= 1'b0;
            end else if (is_access && !halted_q) begin
              err_q <= 1'b1;
            end else if (dbg.mem_wr || dbg.mem_rd) begin
              dmem_req   <= 1'b1;
              dmem_we    <= dbg.mem_wr;
              dmem_size  <= dbg.mem_size;
              dmem_addr  <= dbg.addr;
              dmem_wdata <= dbg.wdata;
              state      <= MEM;
            end else if (dbg.reg_wr) begin
              rf_en    <= 1'b1;
              rf_we    <= |dbg.addr[4:0];
              rf_addr  <= dbg.addr[4:0];
              rf_wdata <= dbg.wdata;
              state    <= REG_WR;
            end else if (dbg.reg_rd) begin
              rf_en   <= 1'b1;
              rf_we   <= 1'b0;
              rf_addr <= dbg.addr[4:0];
              state   <= REG_RD;
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            halted_q <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RST: begin
          if (cnt == '0) begin
            cpu_rst <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we)
              rdata_q <= size_mask(dmem_size, dmem_rdata);
            state <= IDLE;
          end
`ifdef DBG_MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            dmem_req <= 1'b0;
            if (!dmem_we)
              rdata_q <= 32'hDEAD_BEEF;
            err_q <= 1'b1;
            state <= IDLE;
          end
`endif
        end
        REG_RD: begin
          rf_en   <= 1'b0;
          rdata_q <= rf_rdata;
          state   <= IDLE;
        end
        REG_WR: begin
          rf_en <= 1'b0;
          rf_we <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dbg_target_port.md
# dbg_target_port

MCU-side responder for the UART debugger's command strobes. Accepts the one-shot `valid` plus command strobes from the debug controller and drives the `busy` handshake the controller waits on. Sequences the actual work on the core: stalling, draining and releasing the pipeline, pulsing core reset, and performing data-memory and register-file accesses. Returns read data to the serial decoder. Sits between the debug controller and the RISC-V core's stall/reset inputs, data-memory port and register-file debug port.

## Interface
- `PAUSE_DRAIN`, 2: cycles `cpu_halt` must be held before the core counts as halted.
- `RST_CYCLES`, 4: length of the `cpu_rst` pulse.
- `MEM_TIMEOUT`, 64: cycles without `dmem_ack` before an access is aborted. Used only with `DBG_MEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: one-shot command qualifier from the controller.
- `pause`, `resume`, `reset`, `mem_rd`, `mem_wr`, `reg_rd`, `reg_wr` in 1 each: command strobes, sampled only when `valid`=1.
- `mem_size` in 2: access size; 0=byte, 1=half, 2=word.
- `addr` in 32: memory address; `addr[4:0]` is the register index.
- `wdata` in 32: write data.
- `busy` out 1: command in progress (combinational).
- `rdata` out 32: last read result (registered).
- `halted` out 1: core is paused.
- `access_err` out 1: one-cycle pulse on a rejected or aborted access.
- `cpu_halt` out 1: core stall.
- `cpu_rst` out 1: core reset.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_size` out 2, `dmem_addr` out 32, `dmem_wdata` out 32: data-memory request.
- `dmem_ack` in 1, `dmem_rdata` in 32: data-memory response.
- `rf_en` out 1, `rf_we` out 1, `rf_addr` out 5, `rf_wdata` out 32: register-file debug port.
- `rf_rdata` in 32: register-file read data, valid the cycle after `rf_en`.

## Operation
- States: `IDLE`, `DRAIN`, `RST`, `MEM`, `REG_RD`, `REG_WR`.
- `busy = valid | (state != IDLE)`.
  - Must be combinational: the controller samples `busy` in the cycle after raising `valid`.
- A command is accepted only in `IDLE` with `valid`=1. `valid` outside `IDLE` is ignored.
- Strobe priority when several are high: reset > pause > resume > mem_wr > mem_rd > reg_wr > reg_rd.
- `valid` with no strobe set: no-op.
- pause:
  - Already `halted`: no-op.
  - Otherwise: set `cpu_halt`, enter `DRAIN` for `PAUSE_DRAIN` cycles, then set `halted` and return to `IDLE`.
- resume: clear `cpu_halt` and `halted`; stay in `IDLE`.
- reset:
  - Assert `cpu_rst` for `RST_CYCLES` cycles (`RST`).
  - Clear `cpu_halt` and `halted` at entry.
  - Return to `IDLE`.
- mem/reg access while `halted`=0: rejected. Pulse `access_err`, leave `rdata` unchanged, stay in `IDLE`.
- mem_rd / mem_wr:
  - `dmem_*` fields are latched from `addr`, `wdata` and `mem_size`; `dmem_we` = mem_wr.
  - `dmem_req` is held until `dmem_ack`.
  - On a read ack: `rdata` = `dmem_rdata` masked by size (byte: `{24'b0,[7:0]}`, half: `{16'b0,[15:0]}`, word: all bits).
- reg_rd: `rf_en` for one cycle, then capture `rf_rdata` into `rdata` (`REG_RD`).
- reg_wr:
  - `rf_en` and `rf_we` for one cycle (`REG_WR`).
  - Index 0: `rf_we` is suppressed, but the command still completes normally.

## Timing
Cycle T is the cycle in which `valid`=1 is seen.
- Reset values: every output 0 (including `rdata`, `halted`, `dmem_size`), state `IDLE`.
- Asserting `rst_n` low mid-operation immediately drops `dmem_req`, `cpu_rst`, `cpu_halt` and `busy`.
- pause (running): `cpu_halt`=1 from T+1; `busy` high T..T+`PAUSE_DRAIN`; `halted`=1 at T+`PAUSE_DRAIN`+1.
- resume: `cpu_halt`=0 from T+1; `busy` high only in T.
- reset: `cpu_rst` high T+1..T+`RST_CYCLES`; `busy` high T..T+`RST_CYCLES`.
- mem:
  - `dmem_req` high from T+1 through the ack cycle A inclusive.
  - `rdata` valid and `busy`=0 at A+1.
  - An ack in T+1 gives the minimum latency: `busy` high for 2 cycles.
- reg_rd: `rf_en` at T+1; `rdata` valid and `busy`=0 at T+2.
- reg_wr: `rf_en`/`rf_we` at T+1; `busy`=0 at T+2.
- Rejected access: `access_err` at T+1; `busy` high only in T.

## Configuration
- With `DBG_MEM_TIMEOUT_EN` defined:
  - A counter starts at `dmem_req` rise.
  - If `MEM_TIMEOUT` cycles elapse with no ack: drop `dmem_req`, set `rdata`=32'hDEADBEEF for reads, pulse `access_err`, return to `IDLE`.
  - The counter clears on every accepted command.
- Without it: `MEM` waits indefinitely for `dmem_ack`, and no timeout counter is built.

## Test plan
- pause, `PAUSE_DRAIN`=2, valid at T -> `cpu_halt`=1 at T+1, `busy` high T..T+2, `halted`=1 at T+3; a second pause -> `busy` high 1 cycle, no change.
- Halted; mem_rd byte `addr`=0x100; memory returns 0xA1B2C3D4 with ack 3 cycles after req -> `dmem_req` high 3 cycles, `rdata`=0x000000D4, `busy` low the cycle after ack.
- Halted; reg_wr idx 0 data 0x55 then reg_rd idx 5 (`rf_rdata`=0x1234) -> no `rf_we` for idx 0; `rdata`=0x00001234 at T+2.
- Running; mem_wr -> `access_err` pulse, `dmem_req` never asserted, `rdata` unchanged.
- Halted, mid-`MEM`: reset and valid strobed -> ignored; `rst_n` low -> `dmem_req`=0 and `busy`=0 immediately, then reset -> `cpu_rst` 4 cycles, `halted`=0.
- `DBG_MEM_TIMEOUT_EN`, `MEM_TIMEOUT`=8, ack never arrives -> `dmem_req` drops after 8 cycles, `rdata`=0xDEADBEEF, `access_err` pulse.
